cyclic_encoder74: RTL and testbench
===================================

# cyclic_encoder74

Systematic (7,4) cyclic-code encoder with generator g(x) = x^3 + x + 1. It forms the transmit end of the (7,4) link: it accepts a 4-bit message over a valid/ready handshake and computes the 3 parity bits with a bit-serial division LFSR. It then presents the 7-bit codeword in parallel and as a serial bitstream, high-degree bit first. The bit ordering (c[6] first) matches the bit-serial syndrome decoder on the receive side.

## Interface
Parameters: none; code length (7), message length (4) and g(x) are fixed.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- m  in  4  message; m[3] is the coefficient of x^3 (highest degree)
- in_valid  in  1  message on m is valid
- in_ready  out  1  encoder can accept a message (high only in IDLE)
- c  out  7  registered codeword {m[3:0], p[2:0]}; holds until the next codeword is loaded
- cw_valid  out  1  one-cycle pulse when c updates
- sout  out  1  serial codeword bit, c[6] first, c[0] last
- sout_valid  out  1  sout carries a codeword bit
- sout_last  out  1  high with the c[0] bit

## Operation
- Code: c(x) = m(x)·x^3 + (m(x)·x^3 mod g(x)); c[6:3] = m, c[2:0] = parity p, where p[2] is the coefficient of x^2.
- LFSR r[2:0]; per shifted message bit b: f = b ^ r[2]; r[2] <= r[1]; r[1] <= r[0] ^ f; r[0] <= f. After m[3], m[2], m[1], m[0] have been shifted in, p = r.
- FSM states:
  - IDLE: in_ready=1. On in_valid && in_ready, latch m into msg, clear r and the bit counter, go to CALC.
  - CALC: 4 cycles, one message bit per edge, msg[3] first; in_ready=0, in_valid ignored. On the 4th edge, load c = {msg, final r}, load the serial shift register with the same value, pulse cw_valid, go to SEND.
  - SEND: 7 cycles; sout = shift register MSB, sout_valid=1; shift left each edge. sout_last=1 on the 7th bit. After the 7th bit go to IDLE.
- Sequencing uses a 3-bit counter; it is reused between CALC and SEND.
- in_valid in any state other than IDLE has no effect; the message is not queued.
- Reset (asynchronous, any state, including mid-CALC or mid-SEND) clears the following, and any partial word is discarded with no cw_valid:
  - state = IDLE
  - r = 0, msg = 0, counter = 0, shift register = 0
  - c = 0, cw_valid = 0, sout = 0, sout_valid = 0, sout_last = 0
  - in_ready = 1 while in IDLE, including during reset
- Every output of m = 0000 is the all-zero codeword. g(x) divides x^7 + 1, so the set of all codewords is closed under cyclic shift.

## Timing
- E0 = the edge where the handshake completes.
  - Edges E1..E4 shift msg[3]..msg[0].
  - c and cw_valid are updated at E4; cw_valid is high for the single cycle after E4.
  - Serial bits occupy the cycles after E4 through E10: the first bit is c[6], in the same cycle as cw_valid.
  - State returns to IDLE at E11, so in_ready is high from the cycle after E11.
- Latency from acceptance to the parallel codeword: 4 clocks. Maximum throughput: 1 codeword per 12 clocks when in_valid is held high.
- Between frames (IDLE and CALC): sout = 0, sout_valid = 0, sout_last = 0.
- All outputs are registered, except in_ready, which decodes state only.

## Test plan
- Reset release, then m=1000 with in_valid pulsed → in_ready falls; 4 clocks later c=7'h45 (1000101) with a single cw_valid pulse; sout = 1,0,0,0,1,0,1 over 7 cycles with sout_last on the 7th.
- Exhaustive sweep of all 16 messages against a reference model of m·x^3 mod g. Spot values:
  - 0000 → 7'h00
  - 0001 → 7'h0B
  - 1010 → 7'h53
  - 1111 → 7'h7F
  
  Every c must also give a zero remainder when divided by g.
- in_valid held high continuously with changing m → only the message present at each IDLE handshake is encoded; exactly one cw_valid per 12 cycles; the messages offered during CALC and SEND are dropped.
- Assert rst during the 3rd SEND bit → all outputs 0 immediately (asynchronous); in_ready = 1; a new message after release encodes correctly with no stale parity.
- Assert rst during CALC → no cw_valid and c stays 0; the next handshake yields the correct codeword.
- Loopback: feed each parallel c, with any single-bit error injected, into the receive-side (7,4) decoder → the decoder restores the original c after its pipeline delay.

Source files
------------

// File: rtl/cyclic_encoder74.sv
// Systematic (7,4) cyclic encoder, g(x) = x^3 + x + 1.
// Bit-serial division LFSR computes parity; codeword is emitted in parallel and serially, c[6] first.
module cyclic_encoder74 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] m,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [6:0] c,
    output logic       cw_valid,
    output logic       sout,
    output logic       sout_valid,
    output logic       sout_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  msg_r;
    logic [3:0]  msg_s;
    logic [2:0]  lfsr_r;
    logic [2:0]  lfsr_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_s;
    logic [6:0]  shreg_r;
    logic [6:0]  shreg_s;
    logic [6:0]  c_r;
    logic [6:0]  c_s;
    logic        cw_valid_r;
    logic        cw_valid_s;
    logic        sout_valid_r;
    logic        sout_valid_s;
    logic        sout_last_r;
    logic        sout_last_s;
    logic        cur_bit_s;

    // One division step: feedback f = b ^ r[2] folds x^3 back onto x + 1.
    function automatic logic [2:0] lfsr_step(input logic [2:0] r, input logic b);
        logic f;
        f = b ^ r[2];
        return {r[1], r[0] ^ f, f};
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-datapath decode; the counter is shared by CALC and SEND.
    always_comb begin
        state_s      = state_r;
        msg_s        = msg_r;
        lfsr_s       = lfsr_r;
        cnt_s        = cnt_r;
        shreg_s      = shreg_r;
        c_s          = c_r;
        cw_valid_s   = 1'b0;
        sout_valid_s = sout_valid_r;
        sout_last_s  = sout_last_r;
        cur_bit_s    = msg_r[2'd3 - cnt_r[1:0]];
        case (state_r)
            IDLE: begin
                sout_valid_s = 1'b0;
                sout_last_s  = 1'b0;
                if (in_valid) begin
                    msg_s   = m;
                    lfsr_s  = 3'd0;
                    cnt_s   = 3'd0;
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                lfsr_s = lfsr_step(lfsr_r, cur_bit_s);
                if (cnt_r == 3'd3) begin
                    c_s          = {msg_r, lfsr_s};
                    shreg_s      = {msg_r, lfsr_s};
                    cw_valid_s   = 1'b1;
                    sout_valid_s = 1'b1;
                    sout_last_s  = 1'b0;
                    cnt_s        = 3'd0;
                    state_s      = SEND;
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            SEND: begin
                // Seven left shifts of a 7-bit register leave it zero, so sout idles low.
                shreg_s = {shreg_r[5:0], 1'b0};
                if (cnt_r == 3'd6) begin
                    sout_valid_s = 1'b0;
                    sout_last_s  = 1'b0;
                    cnt_s        = 3'd0;
                    state_s      = IDLE;
                end else begin
                    sout_valid_s = 1'b1;
                    sout_last_s  = (cnt_r == 3'd5);
                    cnt_s        = cnt_r + 3'd1;
                end
            end
            default: begin
                state_s      = IDLE;
                cnt_s        = 3'd0;
                shreg_s      = 7'd0;
                sout_valid_s = 1'b0;
                sout_last_s  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_r        <= 4'd0;
            lfsr_r       <= 3'd0;
            cnt_r        <= 3'd0;
            shreg_r      <= 7'd0;
            c_r          <= 7'd0;
            cw_valid_r   <= 1'b0;
            sout_valid_r <= 1'b0;
            sout_last_r  <= 1'b0;
        end else begin
            msg_r        <= msg_s;
            lfsr_r       <= lfsr_s;
            cnt_r        <= cnt_s;
            shreg_r      <= shreg_s;
            c_r          <= c_s;
            cw_valid_r   <= cw_valid_s;
            sout_valid_r <= sout_valid_s;
            sout_last_r  <= sout_last_s;
        end
    end

    assign in_ready   = (state_r == IDLE);
    assign c          = c_r;
    assign cw_valid   = cw_valid_r;
    assign sout       = shreg_r[6];
    assign sout_valid = sout_valid_r;
    assign sout_last  = sout_last_r;

endmodule

// File: tb/tb_cyclic_encoder74.sv
// Self-checking bench for cyclic_encoder74: polynomial-division reference model,
// directed and randomized messages, reset mid-frame, held in_valid, single-error loopback.
module tb_cyclic_encoder74;

    logic       clk;
    logic       rst;
    logic [3:0] m;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] c;
    logic       cw_valid;
    logic       sout;
    logic       sout_valid;
    logic       sout_last;

    int errors;
    int checks;

    cyclic_encoder74 dut (
        .clk        (clk),
        .rst        (rst),
        .m          (m),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .c          (c),
        .cw_valid   (cw_valid),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder of v(x) divided by g(x) = x^3 + x + 1, by long division.
    function automatic logic [2:0] mod_g(input logic [6:0] v);
        logic [6:0] t;
        t = v;
        for (int b = 6; b >= 3; b--) begin
            if (t[b]) t = t ^ (7'b0001011 << (b - 3));
        end
        return t[2:0];
    endfunction

    function automatic logic [6:0] ref_cw(input logic [3:0] mm);
        return {mm, mod_g({mm, 3'b000})};
    endfunction

    // Receive-side single-error corrector: syndrome lookup over the 7 error positions.
    function automatic logic [6:0] decode(input logic [6:0] rx);
        logic [2:0] syn;
        logic [6:0] e;
        syn = mod_g(rx);
        e = 7'd0;
        for (int k = 0; k < 7; k++) begin
            if (syn != 3'd0 && mod_g(7'd1 << k) == syn) e = 7'd1 << k;
        end
        return rx ^ e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for in_ready, then offers mm for one cycle; returns at the negedge after E0.
    task automatic send_msg(input logic [3:0] mm);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", in_ready, 1);
        m = mm;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        m = 4'($urandom);
        check("busy_after_accept", in_ready, 0);
    endtask

    // Follows one frame from the negedge after E0 to the negedge after E11.
    task automatic expect_word(input logic [6:0] exp);
        int lat;
        logic [6:0] ser;
        logic ok;
        lat = 0;
        while (!cw_valid && lat < 20) begin
            check("no_serial_in_calc", sout_valid, 0);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 4);
        check("codeword", c, exp);
        check("syndrome_zero", mod_g(c), 0);
        ok = 1'b1;
        for (int j = 0; j < 7; j++) begin
            if (decode(c ^ (7'd1 << j)) !== exp) ok = 1'b0;
        end
        check("loopback_correct", ok, 1);
        ser = 7'd0;
        for (int i = 0; i < 7; i++) begin
            check("sout_valid", sout_valid, 1);
            check("sout_last", sout_last, (i == 6) ? 1 : 0);
            check("cw_valid_pulse", cw_valid, (i == 0) ? 1 : 0);
            ser = {ser[5:0], sout};
            @(negedge clk);
        end
        check("serial_word", ser, exp);
        check("idle_sout_valid", sout_valid, 0);
        check("idle_sout", sout, 0);
        check("ready_after_frame", in_ready, 1);
        check("c_holds", c, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_c"}, c, 0);
        check({tag, "_cw_valid"}, cw_valid, 0);
        check({tag, "_sout"}, sout, 0);
        check({tag, "_sout_valid"}, sout_valid, 0);
        check({tag, "_sout_last"}, sout_last, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        logic [3:0] q[$];
        logic [3:0] mm;
        int off;
        int last_cw;
        int n_cw;
        int seen_cw;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        m = 4'd0;
        in_valid = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Directed first frame and spot values.
        send_msg(4'b1000);
        expect_word(7'h45);
        send_msg(4'b0000);
        expect_word(7'h00);
        send_msg(4'b0001);
        expect_word(7'h0B);
        send_msg(4'b1010);
        expect_word(7'h53);
        send_msg(4'b1111);
        expect_word(7'h7F);

        // Exhaustive sweep in a randomly rotated order, then random messages.
        off = $urandom_range(15, 0);
        for (int i = 0; i < 16; i++) begin
            mm = 4'((i + off) & 15);
            send_msg(mm);
            expect_word(ref_cw(mm));
        end
        for (int i = 0; i < 6; i++) begin
            mm = 4'($urandom);
            send_msg(mm);
            expect_word(ref_cw(mm));
        end

        // in_valid held high with a new message every cycle.
        in_valid = 1'b1;
        last_cw = -1;
        n_cw = 0;
        for (int cyc = 0; cyc < 62; cyc++) begin
            m = 4'($urandom);
            if (in_ready) q.push_back(m);
            @(negedge clk);
            if (cw_valid) begin
                n_cw++;
                if (last_cw >= 0) check("cw_spacing", cyc - last_cw, 12);
                last_cw = cyc;
                if (q.size() > 0) check("held_codeword", c, ref_cw(q.pop_front()));
                else check("held_queue_nonempty", 0, 1);
            end
        end
        in_valid = 1'b0;
        check("held_cw_count", n_cw, 5);
        repeat (14) @(negedge clk);

        // Reset during the 3rd serial bit.
        mm = 4'($urandom);
        send_msg(mm);
        repeat (4) @(negedge clk);
        repeat (2) @(negedge clk);
        check("third_bit_valid", sout_valid, 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_send");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_rst_send");
        mm = 4'($urandom);
        send_msg(mm);
        expect_word(ref_cw(mm));

        // Reset during CALC: the partial word must vanish.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_msg(4'b0110);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_calc");
        @(negedge clk);
        rst = 1'b0;
        seen_cw = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cw_valid) seen_cw++;
        end
        check("no_cw_after_calc_rst", seen_cw, 0);
        check("c_zero_after_calc_rst", c, 0);
        mm = 4'($urandom);
        send_msg(mm);
        expect_word(ref_cw(mm));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
